change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Coin-side counterpart of the vending machine's coin acceptor. Takes a change amount,
//  pays it out one one-hot coin per cycle in the acceptor's coding (001=5, 010=10, 100=20),
//  largest coin first. Tracks a per-denomination coin inventory and reports any shortfall.
//  Sits between the vending FSM's change output and the physical coin-release drivers.
// PARAMETERS
//  AMT_W   8  width of change amount / remaining
//  CNT_W   4  width of each inventory counter (saturates at 2**CNT_W-1)
//  INIT_5  4  number of 5-coins loaded at reset
//  INIT_10 4  number of 10-coins loaded at reset
//  INIT_20 4  number of 20-coins loaded at reset
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   1      change request strobe
//  req_amount   in   AMT_W  change to pay out, sampled on accept
//  req_ready    out  1      1 only in IDLE; request accepted when req_valid & req_ready
//  refill       in   1      add one coin of refill_coin to inventory this cycle
//  refill_coin  in   3      one-hot denomination being refilled
//  coin_valid   out  1      a coin is released this cycle
//  coin_out     out  3      one-hot coin released; 000 when coin_valid=0
//  busy         out  1      1 in DISPENSE and DONE
//  done         out  1      one-cycle pulse at end of transaction
//  short        out  1      last transaction left an unpaid remainder; held until next accept
//  remaining    out  AMT_W  unpaid remainder of last transaction; held until next accept
//  cnt5/cnt10/cnt20 out CNT_W  current inventory counts
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rem=0, coin_valid=0, coin_out=000, done=0, short=0,
//   remaining=0, busy=0, req_ready=1, cnt5/10/20 = INIT_5/INIT_10/INIT_20. Reset mid-dispense
//   aborts the transaction; unreleased change is lost (no done pulse).
//  FSM: IDLE -> DISPENSE -> DONE -> IDLE.
//   IDLE: on req_valid at edge N: rem<=req_amount, short<=0, remaining<=0, go DISPENSE.
//   DISPENSE: eligible coin c = largest of 20,10,5 with c<=rem and cnt_c>0.
//    If eligible: coin_valid=1, coin_out=code(c) combinationally this cycle; at edge rem<=rem-c,
//    cnt_c decremented; stay. If none eligible (incl. rem=0): coin_valid=0, go DONE.
//   DONE: done=1 for this cycle; short<=(rem!=0), remaining<=rem; go IDLE.
//  Timing: accept at edge N; coins on cycles N+1..N+k (back-to-back); empty cycle N+k+1;
//   done at N+k+2; req_ready high again at N+k+3. Amount 0 -> done at N+2, no coins.
//  Amounts not a multiple of 5: residue (amount mod 5 plus any stock shortfall) reported in
//   remaining with short=1; never over-pay.
//  req_valid while req_ready=0 is ignored (not queued).
//  Refill: accepted in any state. Exactly-one-hot refill_coin increments matching counter,
//   saturating at max; 000 or multi-hot ignored. Refill and dispense of same coin in the same
//   cycle: count unchanged. A coin refilled during DISPENSE is eligible from the next cycle.
//  Arithmetic: rem unsigned AMT_W, subtraction only when c<=rem, so no underflow.
// TESTING
//  1 INIT 4/4/4, req 35 at N -> 100@N+1, 010@N+2, 001@N+3, done@N+5, short=0, remaining=0, counts 3/3/3.
//  2 INIT_20=0, req 40 -> four 010 coins back-to-back, short=0, cnt10=0, cnt20=0.
//  3 INIT 1/1/1, req 50 -> 100,010,001 then done, short=1, remaining=15, all counts 0.
//  4 req 7 -> one 001 coin, done, short=1, remaining=2; req 0 -> no coins, done at N+2.
//  5 cnt5=15 refill 001 -> stays 15; refill 010 during 010 release -> cnt10 unchanged; refill 011 -> ignored.
//  6 reset during 2nd coin of req 35 -> coin_valid=0 at once, counts back to INIT, no done; req_valid while busy ignored.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, coin-release, refill and inventory signals of the change dispenser
//  master: vending FSM / refill side (drives req_*, refill*), observes everything else
//  slave : the dispenser itself
interface change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             refill;
    logic [2:0]       refill_coin;
    logic             coin_valid;
    logic [2:0]       coin_out;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] cnt5;
    logic [CNT_W-1:0] cnt10;
    logic [CNT_W-1:0] cnt20;

    modport master (
        output req_valid, req_amount, refill, refill_coin,
        input  req_ready, coin_valid, coin_out, busy, done, short, remaining, cnt5, cnt10, cnt20
    );
    modport slave (
        input  req_valid, req_amount, refill, refill_coin,
        output req_ready, coin_valid, coin_out, busy, done, short, remaining, cnt5, cnt10, cnt20
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one one-hot coin per cycle (001=5, 010=10, 100=20),
//  largest coin first, from a saturating per-denomination inventory; reports any shortfall.
//  Ports: clk, reset (async, active-high), bus (change_dispenser_if.slave) carrying the
//  request handshake, refill port, coin release, status (busy/done/short/remaining) and counts.
module change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int CNT_W   = 4,
    parameter int INIT_5  = 4,
    parameter int INIT_10 = 4,
    parameter int INIT_20 = 4
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [AMT_W-1:0]       rem;
    logic [2:0][CNT_W-1:0]  cnt;
    logic [2:0]             pick;
    logic [2:0]             inc;
    logic [AMT_W-1:0]       coin_val;

    // pick is one-hot: the largest denomination that fits the remainder and is in stock
    always_comb begin
        pick[2]  = state == DISPENSE && rem >= AMT_W'(20) && cnt[2] != '0;
        pick[1]  = state == DISPENSE && rem >= AMT_W'(10) && cnt[1] != '0 && !pick[2];
        pick[0]  = state == DISPENSE && rem >= AMT_W'(5)  && cnt[0] != '0 && !pick[2] && !pick[1];
        coin_val = pick[2] ? AMT_W'(20) : pick[1] ? AMT_W'(10) : pick[0] ? AMT_W'(5) : '0;
        inc      = (bus.refill && $onehot(bus.refill_coin)) ? bus.refill_coin : 3'b000;
    end

    assign bus.coin_out   = pick;
    assign bus.coin_valid = |pick;
    assign bus.req_ready  = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.cnt5       = cnt[0];
    assign bus.cnt10      = cnt[1];
    assign bus.cnt20      = cnt[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            bus.short     <= 1'b0;
            bus.remaining <= '0;
            cnt           <= {CNT_W'(INIT_20), CNT_W'(INIT_10), CNT_W'(INIT_5)};
        end else begin
            // a refill and a release of the same coin cancel out
            for (int i = 0; i < 3; i++) begin
                if (inc[i] && !pick[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (pick[i] && !inc[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
            case (state)
                IDLE: if (bus.req_valid) begin
                    rem           <= bus.req_amount;
                    bus.short     <= 1'b0;
                    bus.remaining <= '0;
                    state         <= DISPENSE;
                end
                DISPENSE: if (|pick) rem <= rem - coin_val;
                          else state <= DONE;
                DONE: begin
                    bus.short     <= rem != '0;
                    bus.remaining <= rem;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random change requests checked against a greedy payout model
module tb_change_dispenser;
    localparam int AMT_W = 8;
    localparam int CNT_W = 4;
    localparam int DEN[3] = '{5, 10, 20};

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    int   mc[3];

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_5(4), .INIT_10(4), .INIT_20(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".cnt5"},  bus.cnt5,  mc[0]);
        chk({tag, ".cnt10"}, bus.cnt10, mc[1]);
        chk({tag, ".cnt20"}, bus.cnt20, mc[2]);
    endtask

    task automatic do_refill(input logic [2:0] c);
        @(negedge clk);
        bus.refill      = 1'b1;
        bus.refill_coin = c;
        @(negedge clk);
        bus.refill      = 1'b0;
        for (int i = 0; i < 3; i++)
            if (c == 3'(1 << i) && mc[i] < 15) mc[i]++;
        chk_counts("refill");
    endtask

    // Model: greedy payout, largest coin first, limited by stock; what cannot be paid stays in rem
    task automatic do_req(input int amt, input bit poke = 1'b0, input bit refill10 = 1'b0);
        logic [2:0] q[$];
        int rem = amt;
        bit refilled = 1'b0;
        for (int i = 2; i >= 0; i--)
            while (rem >= DEN[i] && mc[i] > 0) begin
                q.push_back(3'(1 << i));
                rem -= DEN[i];
                mc[i]--;
            end
        @(negedge clk);
        chk("ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(amt);
        @(negedge clk);
        bus.req_valid = 1'b0;
        foreach (q[i]) begin
            chk("coin_out", bus.coin_out, q[i]);
            chk("coin_valid", bus.coin_valid, 1);
            chk("busy_disp", bus.busy, 1);
            if (refill10 && !refilled && q[i] == 3'b010) begin
                bus.refill      = 1'b1;
                bus.refill_coin = 3'b010;
                refilled        = 1'b1;
                if (mc[1] < 15) mc[1]++;
            end else
                bus.refill = 1'b0;
            @(negedge clk);
        end
        bus.refill = 1'b0;
        chk("empty_valid", bus.coin_valid, 0);
        chk("empty_out", bus.coin_out, 0);
        chk("empty_done", bus.done, 0);
        chk("ready_busy", bus.req_ready, 0);
        if (poke) begin
            bus.req_valid  = 1'b1;
            bus.req_amount = 8'd5;
        end
        @(negedge clk);
        chk("done", bus.done, 1);
        chk("busy_done", bus.busy, 1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("busy_after", bus.busy, 0);
        chk("short", bus.short, rem != 0);
        chk("remaining", bus.remaining, rem);
        chk_counts("req");
    endtask

    initial begin
        logic [2:0] rc;
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_amount  = '0;
        bus.refill      = 1'b0;
        bus.refill_coin = 3'b000;
        mc              = '{4, 4, 4};
        #12;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.coin_valid, 0);
        chk("rst_out", bus.coin_out, 0);
        chk("rst_short", bus.short, 0);
        chk("rst_rem", bus.remaining, 0);
        chk_counts("rst");
        @(negedge clk);
        reset = 1'b0;

        do_req(35);
        do_req(60);
        do_refill(3'b010);
        do_req(40);
        do_req(50);
        do_refill(3'b001);
        do_refill(3'b001);
        do_refill(3'b010);
        do_refill(3'b100);
        do_req(7);
        do_req(0);
        while (mc[0] < 15) do_refill(3'b001);
        do_refill(3'b001);
        do_refill(3'b011);
        do_refill(3'b000);
        do_refill(3'b111);
        do_req(15, 1'b0, 1'b1);
        do_req(25, 1'b1);

        // reset in the middle of a payout: coins stop at once and no done follows
        reset = 1'b1;
        #1;
        reset = 1'b0;
        mc = '{4, 4, 4};
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_amount = 8'd35;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_c1", bus.coin_out, 3'b100);
        @(negedge clk);
        chk("abort_c2", bus.coin_out, 3'b010);
        reset = 1'b1;
        #1;
        chk("abort_valid", bus.coin_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.req_ready, 1);
        chk_counts("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", bus.done, 0);
            chk("abort_idle", bus.busy, 0);
        end

        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < int'($urandom_range(0, 3)); r++) begin
                rc = 3'($urandom_range(0, 7));
                do_refill(rc);
            end
            do_req(int'($urandom_range(0, 130)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
